sm_addsub_pipe: RTL and testbench

Parametrised, pipelined sign-magnitude adder/subtractor with valid/ready handshaking, replacing the fixed 32-bit combinational sign-magnitude adder in the arithmetic datapath. It accepts one operand pair per cycle, performs add or subtract on WIDTH-bit sign-magnitude numbers, and delivers results two cycles later. Results carry overflow and zero flags and are never negative zero. It sits between the operand-fetch logic and the result writeback buffer, and honours downstream backpressure.

---
 rtl/sm_arith_pkg.sv | 30 +++
 rtl/sm_addsub_pipe_mag.sv | 53 +++++
 rtl/sm_addsub_pipe.sv | 90 +++++++++
 tb/tb_sm_addsub_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm_arith_pkg.sv
// Shared types for the sign-magnitude add/subtract pipeline.
// Holds the op encoding, the S1 stage entry and the saturation helper.
package sm_arith_pkg;

    // Widest supported magnitude container.
    // Supports WIDTH up to 64, which gives at most 63 magnitude bits.
    localparam int SM_MAG_W = 64;

    typedef enum logic {
        SM_ADD = 1'b0,
        SM_SUB = 1'b1
    } sm_op_e;

    // Effective operands after the op is folded into b's sign.
    // Magnitudes are zero-extended into SM_MAG_W bits.
    typedef struct packed {
        logic                sign_a;
        logic                sign_b;
        logic [SM_MAG_W-1:0] mag_a;
        logic [SM_MAG_W-1:0] mag_b;
        logic                same_sign;
        logic                a_ge_b;
    } sm_s1_t;

    // Largest magnitude for a given total width: 2^(width-1)-1.
    function automatic logic [SM_MAG_W-1:0] sm_sat_mag(input int width);
        return (SM_MAG_W'(1) << (width - 1)) - SM_MAG_W'(1);
    endfunction

endpackage

// File: rtl/sm_addsub_pipe_mag.sv
// Combinational magnitude add/subtract for one S1 entry.
// In: s1 entry. Out: res_mag, res_sign, res_ovf. Option macro: SM_ADDSUB_SATURATE_EN.
module sm_mag_addsub
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  sm_s1_t           s1,
    output logic [WIDTH-2:0] res_mag,
    output logic             res_sign,
    output logic             res_ovf
);

`ifdef SM_ADDSUB_SATURATE_EN
    localparam logic [SM_MAG_W-1:0] SAT_MAG = sm_sat_mag(WIDTH);
`endif

    logic [SM_MAG_W-1:0] res_full;
    logic                sign_raw;

    always_comb begin
        res_full = '0;
        sign_raw = 1'b0;
        unique case (1'b1)
            s1.same_sign: begin
                res_full = s1.mag_a + s1.mag_b;
                sign_raw = s1.sign_a;
            end
            !s1.same_sign && s1.a_ge_b: begin
                res_full = s1.mag_a - s1.mag_b;
                sign_raw = s1.sign_a;
            end
            !s1.same_sign && !s1.a_ge_b: begin
                res_full = s1.mag_b - s1.mag_a;
                sign_raw = s1.sign_b;
            end
        endcase
    end

    // Inputs are zero-extended, so any set bit at or above
    // WIDTH-1 is the carry out of the magnitude field.
    assign res_ovf = s1.same_sign && (|res_full[SM_MAG_W-1:WIDTH-1]);

`ifdef SM_ADDSUB_SATURATE_EN
    assign res_mag = res_ovf ? SAT_MAG[WIDTH-2:0] : res_full[WIDTH-2:0];
`else
    assign res_mag = res_full[WIDTH-2:0];
`endif

    // Never produce negative zero.
    assign res_sign = sign_raw && (res_mag != '0);

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor, valid/ready both sides.
// Ports: clk, rst_n, in_valid/in_ready/in_op/in_a/in_b, out_valid/out_ready/out_sum/out_ovf/out_zero. Option macro: SM_ADDSUB_SATURATE_EN.
module sm_addsub_pipe
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_zero
);

    logic             s1_valid;
    sm_s1_t           s1_q;
    sm_s1_t           s1_d;
    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-2:0] mag_a;
    logic [WIDTH-2:0] mag_b;
    logic [WIDTH-2:0] res_mag;
    logic             res_sign;
    logic             res_ovf;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    assign mag_a = in_a[WIDTH-2:0];
    assign mag_b = in_b[WIDTH-2:0];

    // Subtraction is addition with b's sign flipped; a zero
    // magnitude always carries a plus sign.
    always_comb begin
        s1_d           = '0;
        s1_d.sign_a    = in_a[WIDTH-1] && (mag_a != '0);
        s1_d.sign_b    = (in_b[WIDTH-1] ^ (sm_op_e'(in_op) == SM_SUB))
                         && (mag_b != '0);
        s1_d.mag_a     = SM_MAG_W'(mag_a);
        s1_d.mag_b     = SM_MAG_W'(mag_b);
        s1_d.same_sign = (s1_d.sign_a == s1_d.sign_b);
        s1_d.a_ge_b    = (mag_a >= mag_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    sm_mag_addsub #(
        .WIDTH(WIDTH)
    ) u_mag (
        .s1      (s1_q),
        .res_mag (res_mag),
        .res_sign(res_sign),
        .res_ovf (res_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= {res_sign, res_mag};
                out_ovf  <= res_ovf;
                out_zero <= (res_mag == '0);
            end
        end
    end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe at WIDTH=8 and WIDTH=32.
// Honours SM_ADDSUB_SATURATE_EN in its reference model.
module tb_sm_addsub_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, op8 = 0, ov8, or8 = 1, f8, z8;
    logic [7:0]  a8 = 0, b8 = 0, s8;
    logic        iv32 = 0, ir32, op32 = 0, ov32, or32 = 1, f32, z32;
    logic [31:0] a32 = 0, b32 = 0, s32;

    int total = 0;
    int bad = 0;

    logic [33:0] q8[$];
    logic [33:0] q32[$];

    sm_addsub_pipe #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_op(op8),
        .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(or8),
        .out_sum(s8), .out_ovf(f8), .out_zero(z8)
    );

    sm_addsub_pipe #(.WIDTH(32)) u_d32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .in_op(op32),
        .in_a(a32), .in_b(b32),
        .out_valid(ov32), .out_ready(or32),
        .out_sum(s32), .out_ovf(f32), .out_zero(z32)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Signed-integer reference: {ovf, zero, sum}.
    function automatic logic [33:0] model(int w, bit op,
                                          logic [31:0] a, logic [31:0] b);
        longint mx, ma, mb, va, vb, r, m;
        bit neg, ovf;
        logic [31:0] s;
        mx = (longint'(1) << (w - 1)) - 1;
        ma = longint'(a) & mx;
        mb = longint'(b) & mx;
        va = a[w-1] ? -ma : ma;
        vb = b[w-1] ? -mb : mb;
        r = op ? va - vb : va + vb;
        neg = (r < 0);
        m = neg ? -r : r;
        ovf = (m > mx);
`ifdef SM_ADDSUB_SATURATE_EN
        if (ovf) m = mx;
`else
        m = m & mx;
`endif
        s = 32'(m);
        if (neg && m != 0) s[w-1] = 1'b1;
        return {ovf, (m == 0), s};
    endfunction

    always @(posedge clk) begin
        if (rst_n && iv8 && ir8)
            q8.push_back(model(8, op8, {24'b0, a8}, {24'b0, b8}));
        if (rst_n && iv32 && ir32)
            q32.push_back(model(32, op32, a32, b32));
    end

    logic        pv8 = 0, pr8 = 0, pv32 = 0, pr32 = 0;
    logic [33:0] ph8 = 0, ph32 = 0;

    // Single compare process for both instances.
    always @(negedge clk) begin
        logic [33:0] e, act;
        if (rst_n) begin
            act = {f8, z8, 24'b0, s8};
            if (ov8 && pv8 && !pr8) chk("hold8", 64'(act), 64'(ph8));
            if (ov8 && or8) begin
                if (q8.size() == 0) chk("stale8", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("res8", 64'(act), 64'(e));
                end
            end
            pv8 = ov8; pr8 = or8; ph8 = act;
            act = {f32, z32, s32};
            if (ov32 && pv32 && !pr32) chk("hold32", 64'(act), 64'(ph32));
            if (ov32 && or32) begin
                if (q32.size() == 0) chk("stale32", 1, 0);
                else begin
                    e = q32.pop_front();
                    chk("res32", 64'(act), 64'(e));
                end
            end
            pv32 = ov32; pr32 = or32; ph32 = act;
        end else begin
            pv8 = 0; pv32 = 0;
        end
    end

    task automatic go8(string nm, bit op, logic [7:0] a, logic [7:0] b,
                       logic [7:0] es, bit eo, bit ez);
        @(negedge clk);
        iv8 = 1; op8 = op; a8 = a; b8 = b;
        chk({nm, "_rdy"}, 64'(ir8), 1);
        @(negedge clk);
        iv8 = 0;
        chk({nm, "_lat1"}, 64'(ov8), 0);
        @(negedge clk);
        chk({nm, "_lat2"}, 64'(ov8), 1);
        chk({nm, "_sum"}, 64'({f8, z8, s8}), 64'({eo, ez, es}));
    endtask

    initial begin
        // Pin the model against hand-computed values.
        chk("pin_add", 64'(model(8, 0, 32'h05, 32'h83)), 64'({2'b00, 32'h02}));
        chk("pin_sub", 64'(model(8, 1, 32'h03, 32'h05)), 64'({2'b00, 32'h82}));
        chk("pin_nz", 64'(model(8, 0, 32'h85, 32'h05)), 64'({2'b01, 32'h00}));
`ifdef SM_ADDSUB_SATURATE_EN
        chk("pin_ovf", 64'(model(8, 0, 32'h7F, 32'h01)), 64'({2'b10, 32'h7F}));
`else
        chk("pin_ovf", 64'(model(8, 0, 32'h7F, 32'h01)), 64'({2'b11, 32'h00}));
`endif

        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ov8", 64'({ov8, s8, f8, z8}), 0);
        chk("rst_ov32", 64'({ov32, s32, f32, z32}), 0);
        chk("rst_rdy", 64'({ir8, ir32}), 64'(2'b11));

        go8("add", 0, 8'h05, 8'h83, 8'h02, 0, 0);
        go8("sub", 1, 8'h03, 8'h05, 8'h82, 0, 0);
        go8("negz", 0, 8'h85, 8'h05, 8'h00, 0, 1);
        go8("mzero", 1, 8'h80, 8'h00, 8'h00, 0, 1);
        go8("eqsub", 1, 8'hC0, 8'hC0, 8'h00, 0, 1);
`ifdef SM_ADDSUB_SATURATE_EN
        go8("ovf", 0, 8'h7F, 8'h01, 8'h7F, 1, 0);
        go8("novf", 0, 8'hFF, 8'h81, 8'hFF, 1, 0);
`else
        go8("ovf", 0, 8'h7F, 8'h01, 8'h00, 1, 1);
        go8("novf", 0, 8'hFF, 8'h81, 8'h00, 1, 1);
`endif

        // Backpressure on the 32-bit instance.
        or32 = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            iv32 = 1; op32 = i[0];
            a32 = 32'h1000 * (i + 1); b32 = 32'h8000_0010 + i;
            chk("bp_rdy_hi", 64'(ir32), 1);
        end
        @(negedge clk);
        iv32 = 0;
        chk("bp_rdy_lo", 64'(ir32), 0);
        repeat (3) @(negedge clk);
        chk("bp_held_v", 64'(ov32), 1);
        for (int i = 2; i < 4; i++) begin
            if (i == 2) or32 = 1;
            iv32 = 1; op32 = 0;
            a32 = 32'h7FFF_FFF0 + i; b32 = 32'h0000_0020;
            chk("bp_ov", 64'(ov32), 1);
            @(negedge clk);
        end
        iv32 = 0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_ov", 64'(ov32), 1);
            @(negedge clk);
        end
        chk("bp_empty", 64'(ov32), 0);

        // Full-throughput random stream on both instances.
        for (int i = 0; i < 100; i++) begin
            iv8 = 1; op8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            iv32 = 1; op32 = 1'($urandom);
            a32 = $urandom; b32 = $urandom;
            if (i % 10 == 0) b32 = a32;
            if (i % 10 == 5) b32 = a32 ^ 32'h8000_0000;
            @(negedge clk);
            chk("tp_rdy", 64'({ir8, ir32}), 64'(2'b11));
        end
        iv8 = 0; iv32 = 0;
        repeat (4) @(negedge clk);
        chk("drain8", 64'(q8.size()), 0);
        chk("drain32", 64'(q32.size()), 0);

        // Reset with two results in flight.
        or32 = 0;
        for (int i = 0; i < 2; i++) begin
            iv32 = 1; op32 = 0; a32 = 32'd100 + i; b32 = 32'd7;
            @(negedge clk);
        end
        iv32 = 0;
        chk("rf_ov_pre", 64'(ov32), 1);
        #2;
        rst_n = 0;
        #1;
        chk("rf_ov_rst", 64'(ov32), 0);
        q32.delete();
        q8.delete();
        @(negedge clk);
        rst_n = 1;
        or32 = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rf_nostale", 64'({ov8, ov32}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
